// File: rtl/hpm_overflow_irq_if.sv
// CSR-side port bundle of the HPM overflow interrupt block: OF write port,
// OF read-back (scountovf view) and the interrupt request/acknowledge pair.
interface hpm_overflow_irq_if #(
   parameter int unsigned N = 6
);
   logic         of_we;
   logic [N-1:0] of_wdata;
   logic [N-1:0] of_wmask;
   logic [N-1:0] of;
   logic         irq;
   logic         irq_ack;

   modport master (
      output of_we, of_wdata, of_wmask, irq_ack,
      input  of, irq
   );

   modport slave (
      input  of_we, of_wdata, of_wmask, irq_ack,
      output of, irq
   );
endinterface

// File: rtl/hpm_overflow_irq.sv
// HPM counter overflow tracking: per-counter OF bits, sticky loss flag and a
// local interrupt with post-acknowledge holdoff.
package config_pkg;
   typedef struct packed {
      logic [31:0] XLEN;
   } cva6_cfg_t;
   localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module hpm_overflow_irq #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
   parameter int unsigned           NumCounters  = 6,
   parameter int unsigned           HoldoffWidth = 8,
   localparam int unsigned          IdxWidth     = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumCounters-1:0]  wrap_i,
   input  logic [NumCounters-1:0]  inhibit_i,
   input  logic [NumCounters-1:0]  ovfie_i,
   input  logic                    debug_mode_i,
   input  logic [HoldoffWidth-1:0] holdoff_i,
   hpm_overflow_irq_if.slave       csr_if,
   output logic [IdxWidth-1:0]     first_idx_o,
   output logic                    lost_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      HOLD = 2'd2
   } state_e;

   // The core configuration is accepted for drop-in compatibility; no field changes this block.
   if (CVA6Cfg.XLEN != 32'd0) begin : g_cfg_xlen
   end

   function automatic logic [IdxWidth-1:0] lowest_idx(input logic [NumCounters-1:0] v);
      logic [IdxWidth-1:0] idx;
      idx = '0;
      for (int i = int'(NumCounters) - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IdxWidth'(i);
         end
      end
      return idx;
   endfunction

   logic [NumCounters-1:0]  of_q, of_d;
   logic                    lost_q, lost_d;
   state_e                  state_q, state_d;
   logic [HoldoffWidth-1:0] hold_cnt_q, hold_cnt_d;
   logic [NumCounters-1:0]  wrap_eff;
   logic                    pend;

   assign wrap_eff = wrap_i & ~inhibit_i;
   assign pend     = |(of_q & ovfie_i);

   always_comb begin
      of_d   = of_q;
      lost_d = lost_q;
      if (csr_if.of_we) begin
         of_d   = (of_q & ~csr_if.of_wmask) | (csr_if.of_wdata & csr_if.of_wmask);
         lost_d = 1'b0;
      end else begin
         lost_d = lost_q;
      end
      // Hardware set and loss detection override any same-cycle software write.
      of_d = of_d | wrap_eff;
      if (|(wrap_eff & of_q)) begin
         lost_d = 1'b1;
      end else begin
         lost_d = lost_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (pend && !debug_mode_i) begin
               state_d = PEND;
            end else begin
               state_d = IDLE;
            end
         end
         PEND: begin
            if (debug_mode_i) begin
               state_d = PEND;
            end else if (csr_if.irq_ack) begin
               if (holdoff_i == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d    = HOLD;
                  hold_cnt_d = holdoff_i;
               end
            end else if (!pend) begin
               state_d = IDLE;
            end else begin
               state_d = PEND;
            end
         end
         HOLD: begin
            hold_cnt_d = hold_cnt_q - HoldoffWidth'(1);
            // A zero count can only arise from corruption; leave rather than wrap.
            if (hold_cnt_q <= HoldoffWidth'(1)) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         of_q       <= '0;
         lost_q     <= 1'b0;
         state_q    <= IDLE;
         hold_cnt_q <= '0;
      end else begin
         of_q       <= of_d;
         lost_q     <= lost_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign csr_if.of  = of_q;
   assign csr_if.irq = (state_q == PEND) && !debug_mode_i;
   assign lost_o     = lost_q;
   assign first_idx_o = lowest_idx(of_q & ovfie_i);

endmodule

// File: tb/tb_hpm_overflow_irq.sv
// Directed vector table plus hand-written multi-cycle sequences for hpm_overflow_irq.
module tb_hpm_overflow_irq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] wrap, inhibit, ovfie;
   logic       debug;
   logic [7:0] holdoff;
   logic [2:0] first_idx;
   logic       lost;
   int         errors = 0;
   int         checks = 0;

   hpm_overflow_irq_if #(.N(6)) csr_if ();

   hpm_overflow_irq #(.NumCounters(6), .HoldoffWidth(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .wrap_i       (wrap),
      .inhibit_i    (inhibit),
      .ovfie_i      (ovfie),
      .debug_mode_i (debug),
      .holdoff_i    (holdoff),
      .csr_if       (csr_if.slave),
      .first_idx_o  (first_idx),
      .lost_o       (lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] wrap, inhibit, ovfie;
      logic       debug, we;
      logic [5:0] wdata, wmask;
      logic [7:0] holdoff;
      logic       ack;
      logic [5:0] e_of;
      logic       e_irq;
      logic [2:0] e_idx;
      logic       e_lost;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic [5:0] w, inh, ie, input logic dbg, we,
                               input logic [5:0] wd, wm, input logic [7:0] ho, input logic ak,
                               input logic [5:0] eof, input logic eirq, input logic [2:0] eidx,
                               input logic elost);
      vec_t v;
      v.wrap = w; v.inhibit = inh; v.ovfie = ie; v.debug = dbg; v.we = we;
      v.wdata = wd; v.wmask = wm; v.holdoff = ho; v.ack = ak;
      v.e_of = eof; v.e_irq = eirq; v.e_idx = eidx; v.e_lost = elost;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wrap = 6'd0; inhibit = 6'd0; debug = 1'b0; holdoff = 8'd0;
      csr_if.of_we = 1'b0; csr_if.of_wdata = 6'd0; csr_if.of_wmask = 6'd0; csr_if.irq_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      //            wrap     inh      ovfie    dbg  we    wdata    wmask    hold ack  e_of     irq  idx  lost
      vecs[0]  = mk(6'h01,  6'h00,  6'h01,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h01, 1'b0, 3'd0, 1'b0);
      vecs[1]  = mk(6'h00,  6'h00,  6'h01,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h01, 1'b1, 3'd0, 1'b0);
      vecs[2]  = mk(6'h04,  6'h00,  6'h01,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h05, 1'b1, 3'd0, 1'b0);
      vecs[3]  = mk(6'h00,  6'h00,  6'h04,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h05, 1'b1, 3'd2, 1'b0);
      vecs[4]  = mk(6'h00,  6'h00,  6'h04,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b1, 6'h05, 1'b0, 3'd2, 1'b0);
      vecs[5]  = mk(6'h00,  6'h00,  6'h04,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h05, 1'b1, 3'd2, 1'b0);
      vecs[6]  = mk(6'h00,  6'h00,  6'h04,  1'b0, 1'b1, 6'h00,  6'h04,  8'd0, 1'b0, 6'h01, 1'b1, 3'd0, 1'b0);
      vecs[7]  = mk(6'h00,  6'h00,  6'h04,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h01, 1'b0, 3'd0, 1'b0);
      vecs[8]  = mk(6'h08,  6'h08,  6'h00,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h01, 1'b0, 3'd0, 1'b0);
      vecs[9]  = mk(6'h30,  6'h00,  6'h30,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h31, 1'b0, 3'd4, 1'b0);
      vecs[10] = mk(6'h10,  6'h00,  6'h30,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h31, 1'b1, 3'd4, 1'b1);
      vecs[11] = mk(6'h00,  6'h00,  6'h30,  1'b0, 1'b1, 6'h00,  6'h00,  8'd0, 1'b0, 6'h31, 1'b1, 3'd4, 1'b0);
      vecs[12] = mk(6'h10,  6'h00,  6'h30,  1'b0, 1'b1, 6'h00,  6'h31,  8'd0, 1'b0, 6'h10, 1'b1, 3'd4, 1'b1);
      vecs[13] = mk(6'h00,  6'h00,  6'h30,  1'b1, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h10, 1'b0, 3'd4, 1'b1);
      vecs[14] = mk(6'h00,  6'h00,  6'h30,  1'b0, 1'b0, 6'h00,  6'h00,  8'd2, 1'b1, 6'h10, 1'b0, 3'd4, 1'b1);
      vecs[15] = mk(6'h00,  6'h00,  6'h30,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h10, 1'b0, 3'd4, 1'b1);
      vecs[16] = mk(6'h00,  6'h00,  6'h30,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b1, 6'h10, 1'b0, 3'd4, 1'b1);
      vecs[17] = mk(6'h00,  6'h00,  6'h30,  1'b0, 1'b0, 6'h00,  6'h00,  8'd0, 1'b0, 6'h10, 1'b1, 3'd4, 1'b1);

      // Reset with activity on the inputs, which must be ignored.
      idle_inputs();
      ovfie = 6'h3f;
      wrap  = 6'h3f;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      wrap  = 6'h00;
      ovfie = 6'h00;
      #1;
      check("reset_of", 32'(csr_if.of), 32'h0);
      check("reset_irq", 32'(csr_if.irq), 32'h0);
      check("reset_lost", 32'(lost), 32'h0);
      check("reset_idx", 32'(first_idx), 32'h0);

      foreach (vecs[i]) begin
         wrap = vecs[i].wrap; inhibit = vecs[i].inhibit; ovfie = vecs[i].ovfie;
         debug = vecs[i].debug; holdoff = vecs[i].holdoff;
         csr_if.of_we = vecs[i].we; csr_if.of_wdata = vecs[i].wdata;
         csr_if.of_wmask = vecs[i].wmask; csr_if.irq_ack = vecs[i].ack;
         tick();
         check($sformatf("v%0d_of", i), 32'(csr_if.of), 32'(vecs[i].e_of));
         check($sformatf("v%0d_irq", i), 32'(csr_if.irq), 32'(vecs[i].e_irq));
         check($sformatf("v%0d_idx", i), 32'(first_idx), 32'(vecs[i].e_idx));
         check($sformatf("v%0d_lost", i), 32'(lost), 32'(vecs[i].e_lost));
      end

      // Reset while in PEND.
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("pend_rst_of", 32'(csr_if.of), 32'h0);
      check("pend_rst_irq", 32'(csr_if.irq), 32'h0);
      check("pend_rst_lost", 32'(lost), 32'h0);

      // Reset while in HOLD with all OF bits set.
      ovfie = 6'h3f;
      wrap  = 6'h3f;
      tick();
      wrap = 6'h00;
      check("all_of", 32'(csr_if.of), 32'h3f);
      tick();
      check("all_irq", 32'(csr_if.irq), 32'h1);
      csr_if.irq_ack = 1'b1;
      holdoff = 8'd10;
      tick();
      csr_if.irq_ack = 1'b0;
      check("hold_irq", 32'(csr_if.irq), 32'h0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("hold_rst_of", 32'(csr_if.of), 32'h0);
      check("hold_rst_irq", 32'(csr_if.irq), 32'h0);
      check("hold_rst_lost", 32'(lost), 32'h0);
      check("hold_rst_idx", 32'(first_idx), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_rst_irq%0d", i), 32'(csr_if.irq), 32'h0);
      end

      // Wrap-to-irq latency: OF one cycle later, irq two cycles later.
      wrap = 6'h20;
      tick();
      wrap = 6'h00;
      check("lat_of", 32'(csr_if.of), 32'h20);
      check("lat_irq_n1", 32'(csr_if.irq), 32'h0);
      check("lat_idx", 32'(first_idx), 32'h5);
      tick();
      check("lat_irq_n2", 32'(csr_if.irq), 32'h1);

      // Holdoff of 4: quiet for 4 HOLD cycles plus one IDLE cycle, then re-raised.
      holdoff = 8'd4;
      csr_if.irq_ack = 1'b1;
      tick();
      csr_if.irq_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("holdoff_quiet%0d", i), 32'(csr_if.irq), 32'h0);
         tick();
      end
      check("holdoff_reraise", 32'(csr_if.irq), 32'h1);

      // Debug mode masks irq for 5 cycles and it returns right after exit.
      debug = 1'b1;
      #1;
      check("dbg_irq0", 32'(csr_if.irq), 32'h0);
      for (int i = 1; i < 5; i++) begin
         tick();
         check($sformatf("dbg_irq%0d", i), 32'(csr_if.irq), 32'h0);
      end
      tick();
      debug = 1'b0;
      #1;
      check("dbg_exit_irq", 32'(csr_if.irq), 32'h1);

      // Same-cycle software clear loses to a wrap; a second wrap flags a loss.
      wrap = 6'h04;
      csr_if.of_we = 1'b1;
      csr_if.of_wmask = 6'h04;
      csr_if.of_wdata = 6'h00;
      tick();
      csr_if.of_we = 1'b0;
      check("setwins_of", 32'(csr_if.of), 32'h24);
      check("setwins_lost", 32'(lost), 32'h0);
      tick();
      wrap = 6'h00;
      check("loss_lost", 32'(lost), 32'h1);
      tick();
      check("loss_sticky", 32'(lost), 32'h1);
      csr_if.of_we = 1'b1;
      csr_if.of_wmask = 6'h00;
      tick();
      csr_if.of_we = 1'b0;
      check("loss_clear", 32'(lost), 32'h0);
      check("loss_clear_of", 32'(csr_if.of), 32'h24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
